uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
Serial receive engine instantiated inside uart_top, directly downstream of the uart_rx_i pin and upstream of the RX data/status registers. It synchronises the line and detects and validates the start bit. It then samples 5-8 data bits, an optional even-parity bit and 1-3 stop bits, using a 16x oversampling strobe from the baud generator. Each received frame is presented as a right-justified byte with a one-cycle done pulse and error flags.

Parameters:
OVERSAMPLE, 16, oversampling ticks per bit; mid-bit sample taken at tick OVERSAMPLE/2-1.
DATA_W_MAX, 8, width of rx_data_o.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
uart_rx_i  in  1  asynchronous serial line, idle high
os_tick_i  in  1  one-cycle strobe at OVERSAMPLE x baud rate
enable_i  in  1  RX enable (control reg bit 16)
parity_en_i  in  1  1 = even parity bit present
stop_width_i  in  2  0=1 bit, 1=2 bits, 2=3 bits, 3=treated as 3 bits
data_width_i  in  2  0=5, 1=6, 2=7, 3=8 data bits
rx_data_o  out  8  last received data, LSB-aligned, unused upper bits 0
rx_done_o  out  1  one-cycle pulse, frame complete
rx_busy_o  out  1  high while a frame is in progress
parity_err_o  out  1  parity error of last frame, valid with rx_done_o
frame_err_o  out  1  stop-bit error of last frame, valid with rx_done_o

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: all outputs 0; FSM in IDLE; synchroniser flops set to 1 (idle line).
- Input path: 2-flop synchroniser on uart_rx_i. All decisions use the synchronised value, which lags the pin by 2 cycles.
- Tick counter: 4 bits (log2 OVERSAMPLE). Advances only on os_tick_i and wraps at OVERSAMPLE-1. Bit counter: 3 bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Enters START on a synchronised falling level (line low) while enable_i=1.
  - On entry: clear the tick counter, latch parity_en_i, stop_width_i and data_width_i for the whole frame, and set rx_busy_o=1.
- START:
  - At tick 7, if the line is low, go to DATA and clear the tick and bit counters.
  - At tick 7, if the line is high (glitch), go to IDLE with rx_busy_o=0 and no done pulse.
- DATA:
  - Sample on every tick 15 (one bit period after the start mid-point).
  - Shift LSB-first into the shift register.
  - After data_width+5 bits, go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY:
  - Sample at tick 15.
  - Error if XOR(data bits, parity bit) != 0 (even parity).
- STOP:
  - Sample each stop bit at tick 15.
  - frame_err is set if any stop sample is 0.
  - After the last stop bit is sampled, in the same cycle:
    - rx_data_o <= shift register, right-justified with upper bits 0;
    - parity_err_o and frame_err_o updated (both 0 when not applicable);
    - rx_done_o = 1 for exactly one cycle;
    - rx_busy_o = 0;
    - FSM returns to IDLE.
- Errored frames still pulse rx_done_o and update rx_data_o.
- rx_data_o and the error flags hold their values until the next rx_done_o.
- enable_i low in any non-IDLE state: abort to IDLE on the next cycle. rx_busy_o=0, no done pulse, rx_data_o and flags unchanged.
- Config inputs changing mid-frame have no effect; the latched copy is used.
- Re-arm: after returning to IDLE a new start is accepted immediately, so back-to-back frames are supported. The line is already low if the stop bit was shortened by a framing error.
- os_tick_i asserted every cycle is legal; no behaviour assumes a minimum tick spacing.
- rst_i mid-frame: all outputs return to reset values on the next edge, and no done pulse is issued.

Test Plan:
1. 8N1, ticks every 4 clk; drive 0xAA LSB-first with 1 stop bit -> one rx_done_o pulse, rx_data_o=0xAA, both errors 0, rx_busy_o high for 10 bit times.
2. 5-bit, even parity, 2 stop; send 0x15 with parity bit 1 -> rx_data_o=0x15, parity_err_o=0. Resend with parity bit 0 -> parity_err_o=1, data still 0x15.
3. 8N1, send 0x55 with stop bit driven 0 -> rx_done_o pulses, frame_err_o=1, rx_data_o=0x55. The next frame 0xAA received correctly -> frame_err_o=0.
4. Line low for 3 ticks only (glitch) -> no rx_done_o, rx_busy_o returns to 0 by tick 8, FSM back in IDLE.
5. Deassert enable_i mid-DATA of 0x3C -> rx_busy_o falls within 1 cycle, no done pulse, rx_data_o keeps its previous value. The next enabled frame 0xC3 -> rx_data_o=0xC3.
6. Five back-to-back 8N1 frames alternating 0xAA/0x55 with no idle gap -> five done pulses with matching data in order, no errors.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receive engine. Validates the start bit, shifts in
// 5-8 data bits LSB-first, checks optional even parity and 1-3 stop bits.
//
// state    | meaning
// S_IDLE   | waiting for a low line while enabled
// S_START  | confirming the start bit at its mid-point
// S_DATA   | sampling data bits once per bit period
// S_PARITY | sampling the even-parity bit
// S_STOP   | sampling stop bits, then publishing the frame
module uart_rx_core #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_W_MAX = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  uart_rx_i,
   input  logic                  os_tick_i,
   input  logic                  enable_i,
   input  logic                  parity_en_i,
   input  logic [1:0]            stop_width_i,
   input  logic [1:0]            data_width_i,
   output logic [DATA_W_MAX-1:0] rx_data_o,
   output logic                  rx_done_o,
   output logic                  rx_busy_o,
   output logic                  parity_err_o,
   output logic                  frame_err_o
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                  state;
   logic                    rx_meta;
   logic                    rx_sync;
   logic [TICK_W-1:0]       tick_cnt;
   logic [TICK_W-1:0]       tick_next;
   logic [2:0]              bit_cnt;
   logic [1:0]              stop_cnt;
   logic [1:0]              stop_last;
   logic                    last_data_bit;
   logic                    par_en_q;
   logic [1:0]              stop_w_q;
   logic [1:0]              data_w_q;
   logic [DATA_W_MAX-1:0]   shift_q;
   logic [DATA_W_MAX-1:0]   data_aligned;
   logic [2:0]              pad_bits;
   logic                    par_acc;
   logic                    par_err_q;
   logic                    frame_err_q;

   // Synchroniser resets to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= uart_rx_i;
         rx_sync <= rx_meta;
      end
   end

   assign tick_next     = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
   assign last_data_bit = (bit_cnt == 3'(data_w_q) + 3'd4);
   assign stop_last     = (stop_w_q == 2'd0) ? 2'd0 :
                          (stop_w_q == 2'd1) ? 2'd1 : 2'd2;

   // Bits enter at the MSB, so short words sit high and need shifting down.
   assign pad_bits      = 3'(DATA_W_MAX - 5) - 3'(data_w_q);
   assign data_aligned  = shift_q >> pad_bits;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         stop_cnt     <= '0;
         par_en_q     <= 1'b0;
         stop_w_q     <= '0;
         data_w_q     <= '0;
         shift_q      <= '0;
         par_acc      <= 1'b0;
         par_err_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_data_o    <= '0;
         rx_done_o    <= 1'b0;
         rx_busy_o    <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         rx_done_o <= 1'b0;
         if (state != S_IDLE && !enable_i) begin
            state     <= S_IDLE;
            rx_busy_o <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (enable_i && !rx_sync) begin
                     state     <= S_START;
                     tick_cnt  <= '0;
                     par_en_q  <= parity_en_i;
                     stop_w_q  <= stop_width_i;
                     data_w_q  <= data_width_i;
                     rx_busy_o <= 1'b1;
                  end
               end

               S_START: begin
                  if (os_tick_i) begin
                     if (tick_cnt == TICK_MID) begin
                        if (!rx_sync) begin
                           state       <= S_DATA;
                           tick_cnt    <= '0;
                           bit_cnt     <= '0;
                           shift_q     <= '0;
                           par_acc     <= 1'b0;
                           par_err_q   <= 1'b0;
                           frame_err_q <= 1'b0;
                        end else begin
                           state     <= S_IDLE;
                           rx_busy_o <= 1'b0;
                        end
                     end else begin
                        tick_cnt <= tick_next;
                     end
                  end
               end

               S_DATA: begin
                  if (os_tick_i) begin
                     tick_cnt <= tick_next;
                     if (tick_cnt == TICK_LAST) begin
                        shift_q <= {rx_sync, shift_q[DATA_W_MAX-1:1]};
                        par_acc <= par_acc ^ rx_sync;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_data_bit) begin
                           state    <= par_en_q ? S_PARITY : S_STOP;
                           stop_cnt <= '0;
                        end
                     end
                  end
               end

               S_PARITY: begin
                  if (os_tick_i) begin
                     tick_cnt <= tick_next;
                     if (tick_cnt == TICK_LAST) begin
                        par_err_q <= par_acc ^ rx_sync;
                        state     <= S_STOP;
                        stop_cnt  <= '0;
                     end
                  end
               end

               S_STOP: begin
                  if (os_tick_i) begin
                     tick_cnt <= tick_next;
                     if (tick_cnt == TICK_LAST) begin
                        if (stop_cnt == stop_last) begin
                           rx_data_o    <= data_aligned;
                           parity_err_o <= par_err_q;
                           frame_err_o  <= frame_err_q | ~rx_sync;
                           rx_done_o    <= 1'b1;
                           rx_busy_o    <= 1'b0;
                           state        <= S_IDLE;
                        end else begin
                           frame_err_q <= frame_err_q | ~rx_sync;
                           stop_cnt    <= stop_cnt + 2'd1;
                        end
                     end
                  end
               end

               default: begin
                  state     <= S_IDLE;
                  rx_busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames from the test plan plus randomized frames,
// all checked against a frame-level model (data mask, parity rule, stop-bit rule).
module tb_uart_rx_core;

   logic tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   logic       rst;
   logic       uart_rx;
   logic       os_tick;
   logic       enable;
   logic       parity_en;
   logic [1:0] stop_width;
   logic [1:0] data_width;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_busy;
   logic       parity_err;
   logic       frame_err;

   uart_rx_core dut (
      .clk_i        (tb_clk),
      .rst_i        (rst),
      .uart_rx_i    (uart_rx),
      .os_tick_i    (os_tick),
      .enable_i     (enable),
      .parity_en_i  (parity_en),
      .stop_width_i (stop_width),
      .data_width_i (data_width),
      .rx_data_o    (rx_data),
      .rx_done_o    (rx_done),
      .rx_busy_o    (rx_busy),
      .parity_err_o (parity_err),
      .frame_err_o  (frame_err)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } frame_t;

   frame_t exp_q[$];
   frame_t last_exp;
   int     n_vec      = 0;
   int     n_err      = 0;
   int     n_done     = 0;
   int     n_sent     = 0;
   int     tick_div   = 4;
   int     div_cnt    = 0;
   int     busy_ticks = 0;
   logic   busy_seen  = 1'b0;
   logic   prev_done  = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      os_tick = 1'b0;
      forever begin
         @(posedge tb_clk);
         #1;
         if (div_cnt >= tick_div - 1) begin
            os_tick = 1'b1;
            div_cnt = 0;
         end else begin
            os_tick = 1'b0;
            div_cnt++;
         end
      end
   end

   // Waits for n oversample ticks as seen by the DUT, then steps just past the edge.
   task automatic bit_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge tb_clk); while (os_tick !== 1'b1);
         #2;
      end
   endtask

   always @(negedge tb_clk) begin : monitor
      frame_t e;
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (rx_busy) busy_seen = 1'b1;
         if (rx_busy && os_tick) busy_ticks++;
         if (rx_done) begin
            n_done++;
            check_val("done_width", prev_done, 0);
            check_val("exp_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_val("rx_data", rx_data, e.data);
               check_val("parity_err", parity_err, e.perr);
               check_val("frame_err", frame_err, e.ferr);
               last_exp = e;
            end
         end
         prev_done = rx_done;
      end
   end

   // Drives one frame in the current format; config pins are scrambled mid-frame.
   task automatic send_frame(input logic [7:0] d, input logic pflip, input logic [2:0] stops);
      int         nb;
      int         ns;
      logic [7:0] m;
      logic       pbit;
      logic       pen_s;
      logic [1:0] sw_s;
      logic [1:0] dw_s;
      frame_t     e;
      nb   = int'(data_width) + 5;
      ns   = (stop_width == 2'd0) ? 1 : (stop_width == 2'd1) ? 2 : 3;
      m    = 8'((1 << nb) - 1);
      pbit = (^(d & m)) ^ pflip;
      e.data = d & m;
      e.perr = parity_en & ((^(d & m)) ^ pbit);
      e.ferr = 1'b0;
      for (int k = 0; k < ns; k++)
         if (!stops[k]) e.ferr = 1'b1;
      exp_q.push_back(e);
      n_sent++;
      pen_s = parity_en;
      sw_s  = stop_width;
      dw_s  = data_width;
      uart_rx = 1'b0;
      bit_ticks(8);
      parity_en  = 1'($urandom);
      stop_width = 2'($urandom);
      data_width = 2'($urandom);
      bit_ticks(8);
      for (int i = 0; i < nb; i++) begin
         uart_rx = d[i];
         bit_ticks(16);
      end
      if (pen_s) begin
         uart_rx = pbit;
         bit_ticks(16);
      end
      for (int k = 0; k < ns; k++) begin
         uart_rx = stops[k];
         if (k == ns - 1 && !stops[k]) begin
            // Short bad stop, then enough idle for the re-armed start to be rejected.
            bit_ticks(12);
            uart_rx = 1'b1;
            bit_ticks(20);
         end else begin
            bit_ticks(16);
         end
      end
      uart_rx    = 1'b1;
      parity_en  = pen_s;
      stop_width = sw_s;
      data_width = dw_s;
   endtask

   task automatic set_fmt(input logic pen, input logic [1:0] sw, input logic [1:0] dw);
      parity_en  = pen;
      stop_width = sw;
      data_width = dw;
   endtask

   initial begin
      int         d0;
      logic [2:0] stops;
      rst     = 1'b1;
      uart_rx = 1'b1;
      enable  = 1'b0;
      set_fmt(1'b0, 2'd0, 2'd3);
      repeat (3) @(posedge tb_clk);
      @(negedge tb_clk);
      check_val("rst_data", rx_data, 0);
      check_val("rst_done", rx_done, 0);
      check_val("rst_busy", rx_busy, 0);
      check_val("rst_perr", parity_err, 0);
      check_val("rst_ferr", frame_err, 0);
      @(posedge tb_clk);
      #2;
      rst    = 1'b0;
      enable = 1'b1;
      bit_ticks(16);

      // 8N1 0xAA and busy duration
      busy_ticks = 0;
      d0 = n_done;
      send_frame(8'hAA, 1'b0, 3'b111);
      bit_ticks(32);
      check_val("t1_done_cnt", n_done, d0 + 1);
      check_val("t1_busy_len", (busy_ticks >= 144) && (busy_ticks <= 160), 1);

      // 5E2 parity good then bad
      set_fmt(1'b1, 2'd1, 2'd0);
      send_frame(8'h15, 1'b0, 3'b111);
      send_frame(8'h15, 1'b1, 3'b111);
      bit_ticks(32);

      // 8N1 framing error then clean frame
      set_fmt(1'b0, 2'd0, 2'd3);
      send_frame(8'h55, 1'b0, 3'b110);
      send_frame(8'hAA, 1'b0, 3'b111);
      bit_ticks(32);

      // start glitch
      d0 = n_done;
      busy_seen = 1'b0;
      uart_rx = 1'b0;
      bit_ticks(3);
      uart_rx = 1'b1;
      bit_ticks(9);
      @(negedge tb_clk);
      check_val("t4_busy_seen", busy_seen, 1);
      check_val("t4_busy_low", rx_busy, 0);
      bit_ticks(16);
      check_val("t4_no_done", n_done, d0);

      // enable drop mid-DATA of 0x3C
      d0 = n_done;
      uart_rx = 1'b0;
      bit_ticks(16);
      for (int i = 0; i < 3; i++) begin
         uart_rx = i[0] ? 1'b0 : 1'b0;
         uart_rx = 8'h3C >> i;
         bit_ticks(16);
      end
      uart_rx = 1'b1;
      bit_ticks(8);
      check_val("t5_busy_pre", rx_busy, 1);
      enable = 1'b0;
      @(posedge tb_clk);
      @(negedge tb_clk);
      check_val("t5_busy_drop", rx_busy, 0);
      bit_ticks(48);
      enable = 1'b1;
      bit_ticks(16);
      check_val("t5_no_done", n_done, d0);
      check_val("t5_data_hold", rx_data, last_exp.data);
      check_val("t5_ferr_hold", frame_err, last_exp.ferr);
      send_frame(8'hC3, 1'b0, 3'b111);
      bit_ticks(32);

      // back-to-back frames
      d0 = n_done;
      for (int i = 0; i < 5; i++)
         send_frame(i[0] ? 8'h55 : 8'hAA, 1'b0, 3'b111);
      bit_ticks(32);
      check_val("t6_done_cnt", n_done, d0 + 5);

      // reset mid-frame
      d0 = n_done;
      uart_rx = 1'b0;
      bit_ticks(40);
      rst = 1'b1;
      @(posedge tb_clk);
      @(negedge tb_clk);
      check_val("rstm_busy", rx_busy, 0);
      check_val("rstm_data", rx_data, 0);
      check_val("rstm_ferr", frame_err, 0);
      @(posedge tb_clk);
      #2;
      rst     = 1'b0;
      uart_rx = 1'b1;
      bit_ticks(32);
      check_val("rstm_no_done", n_done, d0);

      // randomized formats, tick rates, parity and stop errors
      for (int f = 0; f < 30; f++) begin
         tick_div = int'($urandom_range(4, 1));
         set_fmt(1'($urandom), 2'($urandom), 2'($urandom));
         for (int k = 0; k < 3; k++) stops[k] = ($urandom_range(5) != 0);
         send_frame(8'($urandom), ($urandom_range(3) == 0), stops);
         if ($urandom_range(1) == 0) bit_ticks(int'($urandom_range(20, 1)));
      end
      bit_ticks(40);
      check_val("queue_empty", exp_q.size(), 0);
      check_val("frames_done", n_done, n_sent);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
